// File: rtl/laji_pipe_ctrl.sv
// rtl/laji_pipe_ctrl.sv - pipeline stall/flush/halt controller; perf counters built only with LAJI_PERF_CNT_EN
module laji_pipe_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load_use,
    input  logic        branch_taken_ps2,
    input  logic        mdu_busy,
    input  logic        halt_ps4,
    input  logic        resume,
    output logic        pc_en,
    output logic        en_vps1,
    output logic        en_vps2,
    output logic        en_vps3,
    output logic        en_vps4,
    output logic        clear_vps1,
    output logic        clear_vps2,
    output logic        clear_vps3,
    output logic        clear_vps4,
    output logic        halted,
    output logic        mdu_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MDU_WAIT, HALTED} state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(MDU_TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_inc;
    logic       r_mdu_timeout;
    logic       w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    // Outputs are forced to all-zero while reset is held, including the active-low clears.
    always_comb begin
        w_next     = r_state;
        w_flush    = 1'b0;
        pc_en      = 1'b1;
        en_vps1    = 1'b1;
        en_vps2    = 1'b1;
        en_vps3    = 1'b1;
        en_vps4    = 1'b1;
        clear_vps1 = 1'b1;
        clear_vps2 = 1'b1;
        clear_vps3 = 1'b1;
        clear_vps4 = 1'b1;
        halted     = 1'b0;
        if (!rst_n) begin
            w_next     = RUN;
            pc_en      = 1'b0;
            en_vps1    = 1'b0;
            en_vps2    = 1'b0;
            en_vps3    = 1'b0;
            en_vps4    = 1'b0;
            clear_vps1 = 1'b0;
            clear_vps2 = 1'b0;
            clear_vps3 = 1'b0;
            clear_vps4 = 1'b0;
        end else if (!en) begin
            pc_en   = 1'b0;
            en_vps1 = 1'b0;
            en_vps2 = 1'b0;
            en_vps3 = 1'b0;
            en_vps4 = 1'b0;
            halted  = (r_state == HALTED);
        end else if (r_state == HALTED) begin
            pc_en   = 1'b0;
            en_vps1 = 1'b0;
            en_vps2 = 1'b0;
            en_vps3 = 1'b0;
            en_vps4 = 1'b0;
            halted  = 1'b1;
            if (resume && !halt_ps4) begin
                w_next = RUN;
            end
        end else if (halt_ps4) begin
            // Let the halting instruction retire while squashing everything behind it.
            w_next     = HALTED;
            w_flush    = 1'b1;
            pc_en      = 1'b0;
            clear_vps1 = 1'b0;
            clear_vps2 = 1'b0;
            clear_vps3 = 1'b0;
        end else if (mdu_busy) begin
            w_next     = MDU_WAIT;
            pc_en      = 1'b0;
            en_vps1    = 1'b0;
            en_vps2    = 1'b0;
            clear_vps3 = 1'b0;
        end else begin
            w_next = RUN;
            if (branch_taken_ps2) begin
                w_flush    = 1'b1;
                clear_vps1 = 1'b0;
                clear_vps2 = 1'b0;
            end else if (load_use) begin
                pc_en      = 1'b0;
                en_vps1    = 1'b0;
                clear_vps2 = 1'b0;
            end
        end
    end

    assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer       <= 8'd0;
            r_mdu_timeout <= 1'b0;
        end else if (en) begin
            if (r_state == MDU_WAIT && w_next == MDU_WAIT) begin
                r_timer <= w_timer_inc;
            end else begin
                r_timer <= 8'd0;
            end
            if (r_state == MDU_WAIT && w_timer_inc == LP_TIMEOUT) begin
                r_mdu_timeout <= 1'b1;
            end
        end
    end

    assign mdu_timeout = r_mdu_timeout;

`ifdef LAJI_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else if (en) begin
            if (!pc_en && r_state != HALTED && r_stall_cnt != 32'hFFFF_FFFF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush && r_flush_cnt != 32'hFFFF_FFFF) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_laji_pipe_ctrl.sv
// tb/tb_laji_pipe_ctrl.sv - directed testbench for laji_pipe_ctrl
module tb_laji_pipe_ctrl;

    // Vector order: {pc_en, en_vps1..4, clear_vps1..4, halted}
    localparam logic [9:0] V_RST  = 10'b0000000000;
    localparam logic [9:0] V_RUN  = 10'b1111111110;
    localparam logic [9:0] V_EN0  = 10'b0000011110;
    localparam logic [9:0] V_EN0H = 10'b0000011111;
    localparam logic [9:0] V_LU   = 10'b0011110110;
    localparam logic [9:0] V_BR   = 10'b1111100110;
    localparam logic [9:0] V_MDU  = 10'b0001111010;
    localparam logic [9:0] V_HENT = 10'b0111100010;
    localparam logic [9:0] V_HALT = 10'b0000011111;

`ifdef LAJI_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load_use = 1'b0;
    logic        branch_taken_ps2 = 1'b0;
    logic        mdu_busy = 1'b0;
    logic        halt_ps4 = 1'b0;
    logic        resume = 1'b0;
    logic        pc_en, en_vps1, en_vps2, en_vps3, en_vps4;
    logic        clear_vps1, clear_vps2, clear_vps3, clear_vps4;
    logic        halted, mdu_timeout;
    logic [31:0] stall_cnt, flush_cnt;
    logic [9:0]  obs;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_flush = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    laji_pipe_ctrl #(.MDU_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load_use(load_use),
        .branch_taken_ps2(branch_taken_ps2), .mdu_busy(mdu_busy),
        .halt_ps4(halt_ps4), .resume(resume), .pc_en(pc_en),
        .en_vps1(en_vps1), .en_vps2(en_vps2), .en_vps3(en_vps3), .en_vps4(en_vps4),
        .clear_vps1(clear_vps1), .clear_vps2(clear_vps2),
        .clear_vps3(clear_vps3), .clear_vps4(clear_vps4),
        .halted(halted), .mdu_timeout(mdu_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign obs = {pc_en, en_vps1, en_vps2, en_vps3, en_vps4,
                  clear_vps1, clear_vps2, clear_vps3, clear_vps4, halted};

    task automatic cyc(input logic e, input logic lu, input logic br,
                       input logic bz, input logic hl, input logic rs);
        @(negedge clk);
        en = e; load_use = lu; branch_taken_ps2 = br;
        mdu_busy = bz; halt_ps4 = hl; resume = rs;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== V_RST) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs, V_RST);
        end
        checks++;
        if (mdu_timeout !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: got to=%b stall=%0d flush=%0d expected 0/0/0",
                     mdu_timeout, stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_use;
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== V_RUN) begin failures++; $display("FAIL lu_idle: got %b expected %b", obs, V_RUN); end
        cyc(1, 1, 0, 0, 0, 0);
        exp_stall++;
        checks++;
        if (obs !== V_LU) begin failures++; $display("FAIL lu_bubble: got %b expected %b", obs, V_LU); end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== V_RUN) begin failures++; $display("FAIL lu_after: got %b expected %b", obs, V_RUN); end
        cyc(0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== V_EN0) begin failures++; $display("FAIL lu_en0: got %b expected %b", obs, V_EN0); end
        @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== (PERF ? exp_stall : 32'd0)) begin
            failures++;
            $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, PERF ? exp_stall : 32'd0);
        end
    endtask

    task automatic test_branch;
        cyc(1, 1, 1, 0, 0, 0);
        exp_flush++;
        checks++;
        if (obs !== V_BR) begin failures++; $display("FAIL br_with_lu: got %b expected %b", obs, V_BR); end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== V_RUN) begin failures++; $display("FAIL br_after: got %b expected %b", obs, V_RUN); end
        checks++;
        if (flush_cnt !== (PERF ? exp_flush : 32'd0) || stall_cnt !== (PERF ? exp_stall : 32'd0)) begin
            failures++;
            $display("FAIL br_counters: got stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt,
                     PERF ? exp_stall : 32'd0, PERF ? exp_flush : 32'd0);
        end
    endtask

    task automatic test_mdu_branch;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 1, 0, 0);
            exp_stall++;
            checks++;
            if (obs !== V_MDU) begin
                failures++;
                $display("FAIL mdu_stall_%0d: got %b expected %b", i, obs, V_MDU);
            end
        end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== V_RUN) begin failures++; $display("FAIL mdu_release: got %b expected %b", obs, V_RUN); end
        @(posedge clk);
        #1;
        checks++;
        if (flush_cnt !== (PERF ? exp_flush : 32'd0) || stall_cnt !== (PERF ? exp_stall : 32'd0)) begin
            failures++;
            $display("FAIL mdu_counters: got stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt,
                     PERF ? exp_stall : 32'd0, PERF ? exp_flush : 32'd0);
        end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 0, 1, 0, 0);
            exp_stall++;
            @(posedge clk);
            #1;
            checks++;
            if (mdu_timeout !== (k >= 5)) begin
                failures++;
                $display("FAIL timeout_cycle_%0d: got %b expected %b", k, mdu_timeout, (k >= 5));
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, 0, 0);
            checks++;
            if (mdu_timeout !== 1'b1 || obs !== V_RUN) begin
                failures++;
                $display("FAIL timeout_sticky_%0d: got to=%b vec=%b expected 1/%b", k, mdu_timeout, obs, V_RUN);
            end
        end
    endtask

    task automatic test_halt;
        cyc(1, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== V_RUN) begin failures++; $display("FAIL resume_in_run: got %b expected %b", obs, V_RUN); end
        cyc(1, 0, 0, 1, 1, 0);
        exp_stall++;
        exp_flush++;
        checks++;
        if (obs !== V_HENT) begin failures++; $display("FAIL halt_entry: got %b expected %b", obs, V_HENT); end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== V_HALT) begin failures++; $display("FAIL halted_idle: got %b expected %b", obs, V_HALT); end
        cyc(1, 1, 1, 1, 0, 0);
        checks++;
        if (obs !== V_HALT) begin failures++; $display("FAIL halted_hazards: got %b expected %b", obs, V_HALT); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== V_EN0H) begin failures++; $display("FAIL halted_en0: got %b expected %b", obs, V_EN0H); end
        cyc(1, 0, 0, 0, 1, 1);
        checks++;
        if (obs !== V_HALT) begin failures++; $display("FAIL resume_with_halt: got %b expected %b", obs, V_HALT); end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== V_HALT) begin failures++; $display("FAIL still_halted: got %b expected %b", obs, V_HALT); end
        cyc(1, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== V_HALT) begin failures++; $display("FAIL resume_cycle: got %b expected %b", obs, V_HALT); end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== V_RUN) begin failures++; $display("FAIL after_resume: got %b expected %b", obs, V_RUN); end
        checks++;
        if (flush_cnt !== (PERF ? exp_flush : 32'd0) || stall_cnt !== (PERF ? exp_stall : 32'd0)) begin
            failures++;
            $display("FAIL halt_counters: got stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt,
                     PERF ? exp_stall : 32'd0, PERF ? exp_flush : 32'd0);
        end
    endtask

    task automatic test_reset_mdu;
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        checks++;
        if (obs !== V_MDU) begin failures++; $display("FAIL pre_reset_mdu: got %b expected %b", obs, V_MDU); end
        cyc(0, 0, 0, 1, 0, 0);
        checks++;
        if (obs !== V_EN0) begin failures++; $display("FAIL pre_reset_en0: got %b expected %b", obs, V_EN0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_RST || mdu_timeout !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got vec=%b to=%b expected %b/0", obs, mdu_timeout, V_RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        mdu_busy = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        checks++;
        if (obs !== V_RUN || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL post_reset: got vec=%b stall=%0d flush=%0d expected %b/0/0",
                     obs, stall_cnt, flush_cnt, V_RUN);
        end
        cyc(1, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== V_LU) begin failures++; $display("FAIL post_reset_lu: got %b expected %b", obs, V_LU); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu_branch();
        test_timeout();
        test_halt();
        test_reset_mdu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
